aes_csr_scoreboard: RTL and testbench

AES_CSR_SCOREBOARD -- requirements
Module: aes_csr_scoreboard

---
 rtl/aes_csr_scoreboard.sv | 230 +++++++++++++++++++++++
 tb/tb_aes_csr_scoreboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_csr_scoreboard.sv
// aes_csr_scoreboard -- passive TL-UL register scoreboard for a CSR block.
// Shadows NUM_REGS word registers from observed writes, tracks outstanding
// requests in order, and checks D-channel responses for opcode and read data.
// Optional first-mismatch log is enabled by defining AES_CSR_SB_LOG_EN;
// without it the log outputs are tied to zero and no log storage exists.
//
// Handshake semantics: a beat is taken on a channel only in a cycle where
// both valid and ready are high; valid without ready (or ready without
// valid) is ignored entirely.
module aes_csr_scoreboard #(
  parameter int                       ADDR_WIDTH = 32,
  parameter int                       DATA_WIDTH = 32,
  parameter int                       NUM_REGS   = 8,
  parameter logic [ADDR_WIDTH-1:0]    BASE_ADDR  = '0,
  parameter int                       DEPTH      = 4,
  parameter logic [NUM_REGS-1:0]      VOLATILE   = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        a_valid_i,
  input  logic                        a_ready_i,
  input  logic [2:0]                  a_opcode_i,
  input  logic [ADDR_WIDTH-1:0]       a_address_i,
  input  logic [DATA_WIDTH-1:0]       a_data_i,
  input  logic [DATA_WIDTH/8-1:0]     a_mask_i,
  input  logic                        d_valid_i,
  input  logic                        d_ready_i,
  input  logic [2:0]                  d_opcode_i,
  input  logic [DATA_WIDTH-1:0]       d_data_i,
  output logic                        mismatch_o,
  output logic                        proto_err_o,
  output logic [15:0]                 err_count_o,
  output logic [$clog2(DEPTH):0]      outstanding_o,
  output logic                        log_valid_o,
  output logic [ADDR_WIDTH-1:0]       log_addr_o,
  output logic [DATA_WIDTH-1:0]       log_exp_o,
  output logic [DATA_WIDTH-1:0]       log_act_o
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_WIDTH-1:0] REGION_BYTES = ADDR_WIDTH'(4 * NUM_REGS);
  localparam logic [CNT_W-1:0]      FULL_COUNT   = CNT_W'(DEPTH);

  localparam logic [2:0] OP_PUT_FULL     = 3'd0;
  localparam logic [2:0] OP_PUT_PARTIAL  = 3'd1;
  localparam logic [2:0] OP_GET          = 3'd4;
  localparam logic [2:0] OP_ACCESS_ACK   = 3'd0;
  localparam logic [2:0] OP_ACCESS_ACK_D = 3'd1;

  // One tracked request: kind, whether it targets a shadowed register,
  // which register, its address and the value a read is expected to return.
  typedef struct packed {
    logic                  rd;
    logic                  hit;
    logic [IDX_W-1:0]      idx;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] exp;
  } entry_t;

  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];
  entry_t                fifo_q   [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q;
  logic [PTR_W-1:0]      rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic                  mismatch_q;
  logic                  proto_err_q;
  logic [15:0]           err_count_q;

  logic                  a_hs;
  logic                  d_hs;
  logic                  a_is_wr;
  logic                  a_is_rd;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  push;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] a_offset;
  logic                  a_hit;
  logic [IDX_W-1:0]      a_idx;
  logic [DATA_WIDTH-1:0] a_exp;
  logic [DATA_WIDTH-1:0] wdata;
  entry_t                head;
  entry_t                new_entry;
  logic                  a_proto;
  logic                  d_proto;
  logic                  mis_d;
  logic                  err_d;

  assign a_hs       = a_valid_i & a_ready_i;
  assign d_hs       = d_valid_i & d_ready_i;
  assign a_is_wr    = (a_opcode_i == OP_PUT_FULL) || (a_opcode_i == OP_PUT_PARTIAL);
  assign a_is_rd    = (a_opcode_i == OP_GET);
  assign fifo_full  = (count_q == FULL_COUNT);
  assign fifo_empty = (count_q == '0);

  // A full tracker refuses the request outright: no push, no shadow update.
  assign push = a_hs & (a_is_wr | a_is_rd) & ~fifo_full;
  assign pop  = d_hs & ~fifo_empty;

  // Address decode: word aligned and inside the shadowed window.
  assign a_offset = a_address_i - BASE_ADDR;
  assign a_hit    = (a_address_i[1:0] == 2'b00) &&
                    (a_address_i >= BASE_ADDR) &&
                    (a_offset < REGION_BYTES);
  assign a_idx    = a_offset[IDX_W+1:2];
  // Expected value is the shadow as it stands before this cycle's write.
  assign a_exp    = a_hit ? shadow_q[a_idx] : '0;

  // Byte-lane merge of write data over the current shadow value.
  always_comb begin
    wdata = a_exp;
    for (int b = 0; b < MASK_W; b++) begin
      if (a_mask_i[b]) begin
        wdata[b*8 +: 8] = a_data_i[b*8 +: 8];
      end
    end
  end

  assign head = fifo_q[rd_ptr_q];

  assign new_entry.rd   = a_is_rd;
  assign new_entry.hit  = a_hit;
  assign new_entry.idx  = a_idx;
  assign new_entry.addr = a_address_i;
  assign new_entry.exp  = a_exp;

  // Error classification for this cycle's handshakes.
  assign a_proto = a_hs & (~(a_is_wr | a_is_rd) | fifo_full);
  assign d_proto = d_hs & (fifo_empty |
                           (head.rd ? (d_opcode_i != OP_ACCESS_ACK_D)
                                    : (d_opcode_i != OP_ACCESS_ACK)));
  assign mis_d   = pop & head.rd & head.hit & ~VOLATILE[head.idx] &
                   (d_data_i != head.exp);
  assign err_d   = mis_d | a_proto | d_proto;

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  // Shadow register file, updated by accepted write hits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (push && a_is_wr && a_hit) begin
      shadow_q[a_idx] <= wdata;
    end
  end

  // In-order request tracker storage and pointers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= new_entry;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Registered error pulses and saturating error counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mismatch_q  <= 1'b0;
      proto_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      mismatch_q  <= mis_d;
      proto_err_q <= a_proto | d_proto;
      if (err_d && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

  assign mismatch_o    = mismatch_q;
  assign proto_err_o   = proto_err_q;
  assign err_count_o   = err_count_q;
  assign outstanding_o = count_q;

`ifdef AES_CSR_SB_LOG_EN
  logic                  log_valid_q;
  logic [ADDR_WIDTH-1:0] log_addr_q;
  logic [DATA_WIDTH-1:0] log_exp_q;
  logic [DATA_WIDTH-1:0] log_act_q;

  // Capture the first data mismatch since reset and hold it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      log_valid_q <= 1'b0;
      log_addr_q  <= '0;
      log_exp_q   <= '0;
      log_act_q   <= '0;
    end else if (mis_d && !log_valid_q) begin
      log_valid_q <= 1'b1;
      log_addr_q  <= head.addr;
      log_exp_q   <= head.exp;
      log_act_q   <= d_data_i;
    end
  end

  assign log_valid_o = log_valid_q;
  assign log_addr_o  = log_addr_q;
  assign log_exp_o   = log_exp_q;
  assign log_act_o   = log_act_q;
`else
  // Stored request addresses only feed the log, which is absent here.
  logic unused_head_addr;
  assign unused_head_addr = ^head.addr;

  assign log_valid_o = 1'b0;
  assign log_addr_o  = '0;
  assign log_exp_o   = '0;
  assign log_act_o   = '0;
`endif

endmodule

// File: tb/tb_aes_csr_scoreboard.sv
// tb_aes_csr_scoreboard -- directed bench for aes_csr_scoreboard.
// Drivers push the hand-computed response {mismatch, proto_err, outstanding,
// err_count} expected one cycle after each handshake; a monitor pops and
// compares after every handshake cycle and checks pulses stay low otherwise.
module tb_aes_csr_scoreboard;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NR    = 8;
  localparam int DEPTH = 4;
  localparam int OW    = 3;
  localparam int W     = 2 + OW + 16;

  logic          clk;
  logic          rst;
  logic          a_valid;
  logic          a_ready;
  logic [2:0]    a_opcode;
  logic [AW-1:0] a_address;
  logic [DW-1:0] a_data;
  logic [3:0]    a_mask;
  logic          d_valid;
  logic          d_ready;
  logic [2:0]    d_opcode;
  logic [DW-1:0] d_data;
  logic          mismatch;
  logic          proto_err;
  logic [15:0]   err_count;
  logic [OW-1:0] outstanding;
  logic          log_valid;
  logic [AW-1:0] log_addr;
  logic [DW-1:0] log_exp;
  logic [DW-1:0] log_act;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         mon_hs;

  aes_csr_scoreboard #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NUM_REGS  (NR),
    .BASE_ADDR (32'h0),
    .DEPTH     (DEPTH),
    .VOLATILE  (8'h04)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .a_valid_i    (a_valid),
    .a_ready_i    (a_ready),
    .a_opcode_i   (a_opcode),
    .a_address_i  (a_address),
    .a_data_i     (a_data),
    .a_mask_i     (a_mask),
    .d_valid_i    (d_valid),
    .d_ready_i    (d_ready),
    .d_opcode_i   (d_opcode),
    .d_data_i     (d_data),
    .mismatch_o   (mismatch),
    .proto_err_o  (proto_err),
    .err_count_o  (err_count),
    .outstanding_o(outstanding),
    .log_valid_o  (log_valid),
    .log_addr_o   (log_addr),
    .log_exp_o    (log_exp),
    .log_act_o    (log_act)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A-channel beat with the response expected one cycle later.
  task automatic a_xfer(input logic [2:0] op, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [3:0] mask,
                        input logic m, input logic p, input logic [OW-1:0] o,
                        input logic [15:0] e);
    @(negedge clk);
    a_valid = 1'b1; a_ready = 1'b1; a_opcode = op;
    a_address = addr; a_data = data; a_mask = mask;
    exp_q.push_back({m, p, o, e});
    @(negedge clk);
    a_valid = 1'b0; a_ready = 1'b0;
  endtask

  // D-channel beat with the response expected one cycle later.
  task automatic d_xfer(input logic [2:0] op, input logic [DW-1:0] data,
                        input logic m, input logic p, input logic [OW-1:0] o,
                        input logic [15:0] e);
    @(negedge clk);
    d_valid = 1'b1; d_ready = 1'b1; d_opcode = op; d_data = data;
    exp_q.push_back({m, p, o, e});
    @(negedge clk);
    d_valid = 1'b0; d_ready = 1'b0;
  endtask

  // Simultaneous A and D beats in one cycle.
  task automatic ad_xfer(input logic [2:0] aop, input logic [AW-1:0] addr,
                         input logic [DW-1:0] adata, input logic [3:0] mask,
                         input logic [2:0] dop, input logic [DW-1:0] ddata,
                         input logic m, input logic p, input logic [OW-1:0] o,
                         input logic [15:0] e);
    @(negedge clk);
    a_valid = 1'b1; a_ready = 1'b1; a_opcode = aop;
    a_address = addr; a_data = adata; a_mask = mask;
    d_valid = 1'b1; d_ready = 1'b1; d_opcode = dop; d_data = ddata;
    exp_q.push_back({m, p, o, e});
    @(negedge clk);
    a_valid = 1'b0; a_ready = 1'b0; d_valid = 1'b0; d_ready = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_outstanding"}, 64'(outstanding), 64'd0);
    check({tag, "_err_count"},   64'(err_count),   64'd0);
    check({tag, "_pulses"},      64'({mismatch, proto_err}), 64'd0);
    check({tag, "_log"},         64'({log_valid, log_addr, log_exp, log_act} != '0), 64'd0);
  endtask

  // Monitor: compare outputs one step after each clock edge.
  always begin
    @(posedge clk);
    mon_hs = (a_valid & a_ready) | (d_valid & d_ready);
    #1;
    if (mon_hs) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL response: got %h with no expected entry queued",
                 {mismatch, proto_err, outstanding, err_count});
      end else begin
        check("response", 64'({mismatch, proto_err, outstanding, err_count}),
              64'(exp_q.pop_front()));
      end
    end else begin
      check("idle_pulses", 64'({mismatch, proto_err}), 64'd0);
    end
  end

  // Stimulus
  initial begin
    rst = 1'b1;
    a_valid = 1'b0; a_ready = 1'b0; a_opcode = '0; a_address = '0; a_data = '0; a_mask = '0;
    d_valid = 1'b0; d_ready = 1'b0; d_opcode = '0; d_data = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;

    // Full write then read back of register 2
    a_xfer(3'd0, 32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 1, 0);
    d_xfer(3'd0, 32'h0,                 0, 0, 0, 0);
    a_xfer(3'd4, 32'h08, 32'h0, 4'hF,   0, 0, 1, 0);
    d_xfer(3'd1, 32'hDEADBEEF,          0, 0, 0, 0);
    check("err_after_clean_rw", 64'(err_count), 64'd0);

    // Partial write merge on register 1, good then stale read data
    a_xfer(3'd0, 32'h04, 32'h11223344, 4'hF,   0, 0, 1, 0);
    d_xfer(3'd0, 32'h0,                        0, 0, 0, 0);
    a_xfer(3'd1, 32'h04, 32'h0000AA00, 4'b0010, 0, 0, 1, 0);
    d_xfer(3'd0, 32'h0,                        0, 0, 0, 0);
    a_xfer(3'd4, 32'h04, 32'h0, 4'hF,          0, 0, 1, 0);
    d_xfer(3'd1, 32'h1122AA44,                 0, 0, 0, 0);
    a_xfer(3'd4, 32'h04, 32'h0, 4'hF,          0, 0, 1, 0);
    d_xfer(3'd1, 32'h11223344,                 1, 0, 0, 1);

    // Volatile register 2 and out-of-window address are not compared
    a_xfer(3'd4, 32'h08, 32'h0, 4'hF, 0, 0, 1, 1);
    d_xfer(3'd1, 32'h12345678,        0, 0, 0, 1);
    a_xfer(3'd4, 32'h40, 32'h0, 4'hF, 0, 0, 1, 1);
    d_xfer(3'd1, 32'hFFFFFFFF,        0, 0, 0, 1);

    // Wrong D opcode for a read, then an illegal A opcode
    a_xfer(3'd4, 32'h04, 32'h0, 4'hF, 0, 0, 1, 1);
    d_xfer(3'd0, 32'h1122AA44,        0, 1, 0, 2);
    a_xfer(3'd2, 32'h04, 32'h0, 4'hF, 0, 1, 0, 3);

    // Second data mismatch (log must keep the first)
    a_xfer(3'd4, 32'h04, 32'h0, 4'hF, 0, 0, 1, 3);
    d_xfer(3'd1, 32'h00000000,        1, 0, 0, 4);

    // Fill the tracker; the fifth request is refused and must not write
    a_xfer(3'd0, 32'h00, 32'hA5A5A5A5, 4'hF, 0, 0, 1, 4);
    a_xfer(3'd4, 32'h00, 32'h0, 4'hF,        0, 0, 2, 4);
    a_xfer(3'd4, 32'h10, 32'h0, 4'hF,        0, 0, 3, 4);
    a_xfer(3'd4, 32'h14, 32'h0, 4'hF,        0, 0, 4, 4);
    a_xfer(3'd0, 32'h00, 32'hFFFFFFFF, 4'hF, 0, 1, 4, 5);
    d_xfer(3'd0, 32'h0,                      0, 0, 3, 5);
    d_xfer(3'd1, 32'hA5A5A5A5,               0, 0, 2, 5);
    d_xfer(3'd1, 32'h0,                      0, 0, 1, 5);
    d_xfer(3'd1, 32'h0,                      0, 0, 0, 5);
    a_xfer(3'd4, 32'h00, 32'h0, 4'hF,        0, 0, 1, 5);
    d_xfer(3'd1, 32'hA5A5A5A5,               0, 0, 0, 5);

    // Simultaneous A and D with one outstanding
    a_xfer(3'd4, 32'h00, 32'h0, 4'hF, 0, 0, 1, 5);
    ad_xfer(3'd4, 32'h04, 32'h0, 4'hF, 3'd1, 32'hA5A5A5A5, 0, 0, 1, 5);
    d_xfer(3'd1, 32'h1122AA44,        0, 0, 0, 5);

    // Simultaneous A and D with tracker empty: D is an error, A still lands
    ad_xfer(3'd0, 32'h1C, 32'h00000077, 4'hF, 3'd0, 32'h0, 0, 1, 1, 6);
    d_xfer(3'd0, 32'h0,               0, 0, 0, 6);

    // Window boundaries: last register, first address past it, unaligned
    a_xfer(3'd4, 32'h1C, 32'h0, 4'hF, 0, 0, 1, 6);
    d_xfer(3'd1, 32'h00000077,        0, 0, 0, 6);
    a_xfer(3'd4, 32'h20, 32'h0, 4'hF, 0, 0, 1, 6);
    d_xfer(3'd1, 32'hDEAD0000,        0, 0, 0, 6);
    a_xfer(3'd4, 32'h1D, 32'h0, 4'hF, 0, 0, 1, 6);
    d_xfer(3'd1, 32'h00000123,        0, 0, 0, 6);

`ifdef AES_CSR_SB_LOG_EN
    check("log_valid", 64'(log_valid), 64'd1);
    check("log_addr",  64'(log_addr),  64'h04);
    check("log_exp",   64'(log_exp),   64'h1122AA44);
    check("log_act",   64'(log_act),   64'h11223344);
`else
    check("log_tied_zero", 64'({log_valid, log_addr, log_exp, log_act} != '0), 64'd0);
`endif

    // Reset with a request in flight
    a_xfer(3'd4, 32'h00, 32'h0, 4'hF, 0, 0, 1, 6);
    rst = 1'b1;
    #2;
    check_idle_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    d_xfer(3'd1, 32'h0,               0, 1, 0, 1);
    a_xfer(3'd4, 32'h04, 32'h0, 4'hF, 0, 0, 1, 1);
    d_xfer(3'd1, 32'h0,               0, 0, 0, 1);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
